// File: rtl/bfly_cmul_combine.sv
// Radix-2 butterfly back end: partial products -> tw = B*W (>>> TW_FRAC), then A +/- tw,
// two-stage valid/ready pipeline with saturation and sticky ovf. Define BFLY_ROUND_EN for round-half-up tw.
module bfly_cmul_combine #(
    parameter int DW        = 24,
    parameter int PW        = 40,
    parameter int TW_FRAC   = 13,
    parameter int OUT_SHIFT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [PW-1:0] p_rr,
    input  logic signed [PW-1:0] p_ii,
    input  logic signed [PW-1:0] p_ri,
    input  logic signed [PW-1:0] p_ir,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x0_re,
    output logic signed [DW-1:0] x0_im,
    output logic signed [DW-1:0] x1_re,
    output logic signed [DW-1:0] x1_im,
    output logic                 ovf,
    input  logic                 ovf_clr
);
    localparam int TW = PW + 1;
    localparam int SW = PW + 2;

    localparam logic signed [SW-1:0] TW_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] TW_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic signed [DW-1:0] D_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN  = {1'b1, {(DW-1){1'b0}}};
`ifdef BFLY_ROUND_EN
    localparam logic signed [SW-1:0] RND_C  = SW'(1) << (TW_FRAC - 1);
`else
    localparam logic signed [SW-1:0] RND_C  = '0;
`endif

    logic                 adv;
    logic                 v1_q, v1_d;
    logic                 out_valid_q, out_valid_d;
    logic                 ovf_q, ovf_d;
    logic signed [DW-1:0] a_q  [2];
    logic signed [DW-1:0] a_d  [2];
    logic signed [TW-1:0] t_q  [2];
    logic signed [TW-1:0] t_d  [2];
    logic signed [DW-1:0] x0_q [2];
    logic signed [DW-1:0] x0_d [2];
    logic signed [DW-1:0] x1_q [2];
    logic signed [DW-1:0] x1_d [2];
    logic signed [DW-1:0] x0_n [2];
    logic signed [DW-1:0] x1_n [2];
    logic [1:0]           lane_sat;

    // Lane 0 is the real part, lane 1 the imaginary part.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        logic signed [SW-1:0] t_rnd, tw_full;
        logic signed [DW-1:0] tw, x0_l, x1_l;
        logic signed [DW:0]   s0, s1;
        logic                 tw_sat, s0_ov, s1_ov;

        always_comb begin
            t_rnd   = $signed({t_q[gi][TW-1], t_q[gi]}) + RND_C;
            tw_full = t_rnd >>> TW_FRAC;
            tw_sat  = (tw_full > TW_MAX) || (tw_full < TW_MIN);
            if (tw_full > TW_MAX)      tw = D_MAX;
            else if (tw_full < TW_MIN) tw = D_MIN;
            else                       tw = tw_full[DW-1:0];
            s0    = $signed({a_q[gi][DW-1], a_q[gi]}) + $signed({tw[DW-1], tw});
            s1    = $signed({a_q[gi][DW-1], a_q[gi]}) - $signed({tw[DW-1], tw});
            s0_ov = s0[DW] ^ s0[DW-1];
            s1_ov = s1[DW] ^ s1[DW-1];
            // Halving the DW+1 sum always fits in DW bits, so that path never saturates.
            if (OUT_SHIFT != 0) begin
                x0_l = s0[DW:1];
                x1_l = s1[DW:1];
            end else begin
                x0_l = s0_ov ? (s0[DW] ? D_MIN : D_MAX) : s0[DW-1:0];
                x1_l = s1_ov ? (s1[DW] ? D_MIN : D_MAX) : s1[DW-1:0];
            end
        end

        assign x0_n[gi]     = x0_l;
        assign x1_n[gi]     = x1_l;
        assign lane_sat[gi] = tw_sat | ((OUT_SHIFT == 0) && (s0_ov || s1_ov));
    end

    always_comb begin
        adv         = en & (~out_valid_q | out_ready);
        v1_d        = v1_q;
        out_valid_d = out_valid_q;
        a_d         = a_q;
        t_d         = t_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        if (adv) begin
            v1_d        = in_valid;
            a_d[0]      = a_re;
            a_d[1]      = a_im;
            t_d[0]      = $signed({p_rr[PW-1], p_rr}) - $signed({p_ii[PW-1], p_ii});
            t_d[1]      = $signed({p_ri[PW-1], p_ri}) + $signed({p_ir[PW-1], p_ir});
            out_valid_d = v1_q;
            // Bubbles leave the last emitted result on the outputs.
            if (v1_q) begin
                x0_d = x0_n;
                x1_d = x1_n;
            end
        end
        // A new saturation wins over a simultaneous clear.
        ovf_d = (adv & v1_q & (|lane_sat)) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                a_q[i]  <= '0;
                t_q[i]  <= '0;
                x0_q[i] <= '0;
                x1_q[i] <= '0;
            end
        end else begin
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < 2; i++) begin
                a_q[i]  <= a_d[i];
                t_q[i]  <= t_d[i];
                x0_q[i] <= x0_d[i];
                x1_q[i] <= x1_d[i];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign x0_re     = x0_q[0];
    assign x0_im     = x0_q[1];
    assign x1_re     = x1_q[0];
    assign x1_im     = x1_q[1];

endmodule
